// File: rtl/spart_driver_pkg.sv
// Shared definitions for the spart bus master: register addresses, baud select codes,
// driver FSM encoding and the divisor function that spart's baud generator also uses.
package spart_driver_pkg;

    localparam logic [1:0] ADDR_BUF  = 2'b00;
    localparam logic [1:0] ADDR_STAT = 2'b01;
    localparam logic [1:0] ADDR_DBL  = 2'b10;
    localparam logic [1:0] ADDR_DBH  = 2'b11;

    typedef enum logic [1:0] {
        BAUD_4800  = 2'd0,
        BAUD_9600  = 2'd1,
        BAUD_19200 = 2'd2,
        BAUD_38400 = 2'd3
    } baud_sel_t;

    typedef enum logic [2:0] {
        CFG_LO = 3'd0,
        CFG_HI = 3'd1,
        IDLE   = 3'd2,
        RD     = 3'd3,
        WR     = 3'd4,
        GAP    = 3'd5
    } state_t;

    function automatic int baud_rate(input logic [1:0] sel);
        int rate;
        case (baud_sel_t'(sel))
            BAUD_4800:  rate = 4800;
            BAUD_9600:  rate = 9600;
            BAUD_19200: rate = 19200;
            default:    rate = 38400;
        endcase
        return rate;
    endfunction

    // 16x oversampling divisor, truncated; both bytes are written to spart.
    function automatic logic [15:0] divisor(input int clk_hz, input logic [1:0] sel);
        int d;
        d = clk_hz / (16 * baud_rate(sel)) - 1;
        return d[15:0];
    endfunction

endpackage

// File: rtl/spart_driver_echo_fifo.sv
// Small synchronous FIFO holding received bytes until the spart transmitter can echo them.
// Head is combinational from the read pointer; push when full and pop when empty are ignored.
module echo_fifo
    import spart_driver_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage is not reset; count gates every read, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == DEPTH[PW:0]);
    assign empty = (count == '0);

endmodule

// File: rtl/spart_driver.sv
// Bus master for one spart: programs the baud divisor from br_cfg, then echoes every
// received byte back out through an internal buffer. Each bus cycle is a one-clock iocs pulse plus a gap.
module spart_driver
    import spart_driver_pkg::*;
#(
    parameter int CLK_HZ     = 100_000_000,
    parameter int ECHO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] br_cfg,
    input  logic       rda,
    input  logic       tbr,
    output logic       iocs,
    output logic       iorw,
    output logic [1:0] ioaddr,
    inout  wire  [7:0] databus
);

    state_t      state;
    state_t      state_d;
    state_t      after_gap;
    state_t      after_gap_d;
    logic [1:0]  cfg_q;
    logic        cfg_load;
    logic        live;
    logic [15:0] div;
    logic        cfg_change;
    logic [7:0]  wr_data;
    logic [7:0]  fifo_head;
    logic        fifo_full;
    logic        fifo_empty;
    logic        push;
    logic        pop;

    assign div        = divisor(CLK_HZ, cfg_q);
    assign cfg_change = (br_cfg != cfg_q);
    assign push       = live && (state == RD);
    assign pop        = live && (state == WR);

    // live is clear for the first cycle after reset so cfg_q holds the released br_cfg before CFG_LO drives the bus.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= CFG_LO;
            after_gap <= IDLE;
            cfg_q     <= 2'd0;
            live      <= 1'b0;
        end else begin
            live      <= 1'b1;
            state     <= state_d;
            after_gap <= after_gap_d;
            if (!live || cfg_load) cfg_q <= br_cfg;
        end
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d     = state;
        after_gap_d = after_gap;
        cfg_load    = 1'b0;
        if (live) begin
            case (state)
                CFG_LO: begin
                    state_d     = GAP;
                    after_gap_d = CFG_HI;
                end
                CFG_HI, RD, WR: begin
                    state_d     = GAP;
                    after_gap_d = IDLE;
                end
                GAP: state_d = after_gap;
                IDLE: begin
                    // Reconfig waits for a drained buffer; while it is pending no new bytes are accepted.
                    if (cfg_change && fifo_empty && tbr) begin
                        cfg_load = 1'b1;
                        state_d  = CFG_LO;
                    end else if (rda && !fifo_full && !cfg_change) begin
                        state_d = RD;
                    end else if (tbr && !fifo_empty) begin
                        state_d = WR;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        iocs    = 1'b0;
        iorw    = 1'b1;
        ioaddr  = ADDR_BUF;
        wr_data = 8'h00;
        if (live) begin
            case (state)
                CFG_LO: begin
                    iocs    = 1'b1;
                    iorw    = 1'b0;
                    ioaddr  = ADDR_DBL;
                    wr_data = div[7:0];
                end
                CFG_HI: begin
                    iocs    = 1'b1;
                    iorw    = 1'b0;
                    ioaddr  = ADDR_DBH;
                    wr_data = div[15:8];
                end
                RD: begin
                    iocs   = 1'b1;
                    iorw   = 1'b1;
                    ioaddr = ADDR_BUF;
                end
                WR: begin
                    iocs    = 1'b1;
                    iorw    = 1'b0;
                    ioaddr  = ADDR_BUF;
                    wr_data = fifo_head;
                end
                default: ;
            endcase
        end
    end

    assign databus = (iocs && !iorw) ? wr_data : 8'bz;

    echo_fifo #(
        .DEPTH (ECHO_DEPTH),
        .WIDTH (8)
    ) u_echo_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (databus),
        .pop       (pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule

// File: tb/tb_spart_driver.sv
// Directed bench for spart_driver: a minimal spart model answers reads and logs every bus cycle;
// each task checks the logged cycles against hand-computed sequences.
module tb_spart_driver;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] br_cfg = 2'd1;
    logic       rda;
    logic       tbr = 1'b0;
    logic       iocs;
    logic       iorw;
    logic [1:0] ioaddr;
    wire  [7:0] databus;

    typedef struct {
        int          cyc;
        logic [10:0] op;   // {iorw, ioaddr, data}
    } bus_t;

    bus_t       bus_log[$];
    logic [7:0] rx_mem[16];
    int         rx_wr = 0;
    int         rx_rd = 0;
    logic [7:0] rx_head;
    logic       pending_pop = 1'b0;
    int         cyc = 0;
    int         n_cmp = 0;
    int         n_bad = 0;

    spart_driver dut (
        .clk     (clk),
        .rst     (rst),
        .br_cfg  (br_cfg),
        .rda     (rda),
        .tbr     (tbr),
        .iocs    (iocs),
        .iorw    (iorw),
        .ioaddr  (ioaddr),
        .databus (databus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // spart model: rda while bytes are queued; a read byte leaves the queue in the following gap.
    assign rda     = (rx_wr != rx_rd);
    assign rx_head = rx_mem[rx_rd[3:0]];
    assign databus = (iocs && iorw && ioaddr == 2'b00) ? rx_head : 8'bz;

    always @(negedge clk) begin
        if (pending_pop) begin
            rx_rd       = rx_rd + 1;
            pending_pop = 1'b0;
        end
        if (iocs) begin
            bus_log.push_back('{cyc, {iorw, ioaddr, databus}});
            if (iorw && ioaddr == 2'b00) pending_pop = 1'b1;
        end
    end

    function automatic logic [10:0] op(input logic rw, input logic [1:0] a, input logic [7:0] d);
        return {rw, a, d};
    endfunction

    task automatic push_rx(input logic [7:0] b);
        rx_mem[rx_wr[3:0]] = b;
        rx_wr = rx_wr + 1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_log(input int n, input int budget, input string tag);
        int k = 0;
        while (bus_log.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        n_cmp++;
        if (bus_log.size() < n) begin
            n_bad++;
            $display("FAIL %s_timeout got %0d bus cycles want %0d", tag, bus_log.size(), n);
        end
    endtask

    task automatic test_reset();
        logic [10:0] exp [$];
        logic [10:0] got;
        int rel;
        #2;
        n_cmp++;
        if (iocs !== 1'b0) begin n_bad++; $display("FAIL rst_iocs got %b want 0", iocs); end
        n_cmp++;
        if (iorw !== 1'b1) begin n_bad++; $display("FAIL rst_iorw got %b want 1", iorw); end
        n_cmp++;
        if (ioaddr !== 2'b00) begin n_bad++; $display("FAIL rst_ioaddr got %b want 00", ioaddr); end
        idle(2);
        bus_log.delete();
        rst = 1'b1;
        rel = cyc;
        wait_log(2, 20, "cfg9600");
        exp = '{op(1'b0, 2'b10, 8'h8A), op(1'b0, 2'b11, 8'h02)};
        for (int i = 0; i < 2; i++) begin
            got = (i < bus_log.size()) ? bus_log[i].op : 11'h7FF;
            n_cmp++;
            if (got !== exp[i]) begin n_bad++; $display("FAIL cfg9600_op%0d got %h want %h", i, got, exp[i]); end
        end
        if (bus_log.size() >= 2) begin
            n_cmp++;
            if (bus_log[0].cyc !== rel + 1) begin
                n_bad++; $display("FAIL cfg_first_latency got %0d want %0d", bus_log[0].cyc - rel, 1);
            end
            n_cmp++;
            if (bus_log[1].cyc !== bus_log[0].cyc + 2) begin
                n_bad++; $display("FAIL cfg_gap got %0d want %0d", bus_log[1].cyc - bus_log[0].cyc, 2);
            end
        end
        idle(8);
        n_cmp++;
        if (bus_log.size() !== 2) begin n_bad++; $display("FAIL cfg_quiet got %0d cycles want 2", bus_log.size()); end
    endtask

    task automatic test_echo();
        logic [10:0] exp [$];
        logic [10:0] got;
        int t0;
        bus_log.delete();
        tbr = 1'b1;
        push_rx(8'h41);
        t0 = cyc;
        wait_log(2, 20, "echo");
        exp = '{op(1'b1, 2'b00, 8'h41), op(1'b0, 2'b00, 8'h41)};
        for (int i = 0; i < 2; i++) begin
            got = (i < bus_log.size()) ? bus_log[i].op : 11'h7FF;
            n_cmp++;
            if (got !== exp[i]) begin n_bad++; $display("FAIL echo_op%0d got %h want %h", i, got, exp[i]); end
        end
        if (bus_log.size() >= 2) begin
            n_cmp++;
            if (bus_log[0].cyc !== t0 + 1) begin
                n_bad++; $display("FAIL rd_latency got %0d want 1", bus_log[0].cyc - t0);
            end
            n_cmp++;
            if (bus_log[1].cyc !== bus_log[0].cyc + 3) begin
                n_bad++; $display("FAIL echo_latency got %0d want 3", bus_log[1].cyc - bus_log[0].cyc);
            end
        end
        idle(6);
        tbr = 1'b0;
        n_cmp++;
        if (bus_log.size() !== 2) begin n_bad++; $display("FAIL echo_empty_wr got %0d cycles want 2", bus_log.size()); end
    endtask

    task automatic test_full();
        logic [10:0] exp [$];
        logic [10:0] got;
        bus_log.delete();
        for (int b = 0; b < 5; b++) push_rx(8'h30 + 8'(b));
        wait_log(4, 40, "fill");
        idle(12);
        n_cmp++;
        if (bus_log.size() !== 4) begin n_bad++; $display("FAIL full_no_read got %0d cycles want 4", bus_log.size()); end
        n_cmp++;
        if (rda !== 1'b1) begin n_bad++; $display("FAIL full_rda_held got %b want 1", rda); end
        exp = '{op(1'b1, 2'b00, 8'h30), op(1'b1, 2'b00, 8'h31), op(1'b1, 2'b00, 8'h32), op(1'b1, 2'b00, 8'h33)};
        for (int i = 0; i < 4; i++) begin
            got = (i < bus_log.size()) ? bus_log[i].op : 11'h7FF;
            n_cmp++;
            if (got !== exp[i]) begin n_bad++; $display("FAIL fill_op%0d got %h want %h", i, got, exp[i]); end
        end
        // Once a slot frees the waiting byte is read ahead of the remaining echoes.
        bus_log.delete();
        tbr = 1'b1;
        wait_log(6, 60, "drain");
        exp = '{op(1'b0, 2'b00, 8'h30), op(1'b1, 2'b00, 8'h34), op(1'b0, 2'b00, 8'h31),
                op(1'b0, 2'b00, 8'h32), op(1'b0, 2'b00, 8'h33), op(1'b0, 2'b00, 8'h34)};
        for (int i = 0; i < 6; i++) begin
            got = (i < bus_log.size()) ? bus_log[i].op : 11'h7FF;
            n_cmp++;
            if (got !== exp[i]) begin n_bad++; $display("FAIL drain_op%0d got %h want %h", i, got, exp[i]); end
        end
        idle(4);
        tbr = 1'b0;
    endtask

    task automatic test_reconfig();
        logic [10:0] exp [$];
        logic [10:0] got;
        bus_log.delete();
        push_rx(8'h51);
        push_rx(8'h52);
        wait_log(2, 30, "rc_fill");
        idle(3);
        br_cfg = 2'd3;
        push_rx(8'h53);
        idle(10);
        n_cmp++;
        if (bus_log.size() !== 2) begin n_bad++; $display("FAIL rc_blocked got %0d cycles want 2", bus_log.size()); end
        bus_log.delete();
        tbr = 1'b1;
        wait_log(6, 80, "reconfig");
        exp = '{op(1'b0, 2'b00, 8'h51), op(1'b0, 2'b00, 8'h52), op(1'b0, 2'b10, 8'hA1),
                op(1'b0, 2'b11, 8'h00), op(1'b1, 2'b00, 8'h53), op(1'b0, 2'b00, 8'h53)};
        for (int i = 0; i < 6; i++) begin
            got = (i < bus_log.size()) ? bus_log[i].op : 11'h7FF;
            n_cmp++;
            if (got !== exp[i]) begin n_bad++; $display("FAIL reconfig_op%0d got %h want %h", i, got, exp[i]); end
        end
        idle(4);
        tbr = 1'b0;
    endtask

    task automatic test_priority();
        logic [10:0] exp [$];
        logic [10:0] got;
        bus_log.delete();
        push_rx(8'h61);
        wait_log(1, 20, "pri_fill");
        idle(4);
        bus_log.delete();
        push_rx(8'h62);
        tbr = 1'b1;
        wait_log(3, 40, "priority");
        exp = '{op(1'b1, 2'b00, 8'h62), op(1'b0, 2'b00, 8'h61), op(1'b0, 2'b00, 8'h62)};
        for (int i = 0; i < 3; i++) begin
            got = (i < bus_log.size()) ? bus_log[i].op : 11'h7FF;
            n_cmp++;
            if (got !== exp[i]) begin n_bad++; $display("FAIL priority_op%0d got %h want %h", i, got, exp[i]); end
        end
        idle(4);
        tbr = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [10:0] exp [$];
        logic [10:0] got;
        int k;
        int rel;
        bus_log.delete();
        push_rx(8'h71);
        wait_log(1, 20, "rm_fill");
        idle(4);
        tbr = 1'b1;
        k = 0;
        while (!(iocs && !iorw) && k < 20) begin
            @(negedge clk);
            k++;
        end
        n_cmp++;
        if (!(iocs && !iorw)) begin n_bad++; $display("FAIL rm_wr_seen got iocs=%b iorw=%b want 1/0", iocs, iorw); end
        #1 rst = 1'b0;
        #1;
        n_cmp++;
        if (iocs !== 1'b0) begin n_bad++; $display("FAIL rm_iocs got %b want 0", iocs); end
        n_cmp++;
        if (iorw !== 1'b1) begin n_bad++; $display("FAIL rm_iorw got %b want 1", iorw); end
        idle(2);
        bus_log.delete();
        rst = 1'b1;
        rel = cyc;
        wait_log(2, 20, "rm_cfg");
        exp = '{op(1'b0, 2'b10, 8'hA1), op(1'b0, 2'b11, 8'h00)};
        for (int i = 0; i < 2; i++) begin
            got = (i < bus_log.size()) ? bus_log[i].op : 11'h7FF;
            n_cmp++;
            if (got !== exp[i]) begin n_bad++; $display("FAIL rm_cfg_op%0d got %h want %h", i, got, exp[i]); end
        end
        if (bus_log.size() >= 1) begin
            n_cmp++;
            if (bus_log[0].cyc !== rel + 1) begin
                n_bad++; $display("FAIL rm_first_latency got %0d want 1", bus_log[0].cyc - rel);
            end
        end
        idle(12);
        n_cmp++;
        if (bus_log.size() !== 2) begin n_bad++; $display("FAIL rm_buffer_empty got %0d cycles want 2", bus_log.size()); end
        tbr = 1'b0;
    endtask

    initial begin
        test_reset();
        test_echo();
        test_full();
        test_reconfig();
        test_priority();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
